polar_block_avg: RTL and testbench

- Post-processing stage directly downstream of topolar in the AC_PH cascade.
- Consumes the (o_mag, o_phase, o_vld) stream from topolar and averages magnitude and phase over blocks of N = 2^LOG2_N valid samples.
- Phase is averaged wrap-safely: each sample is taken as an offset from the block's first phase, so clusters straddling ±pi average correctly.
- Emits one averaged (mag, phase) pair per block.

---
 rtl/polar_block_avg_pkg.sv | 24 ++
 rtl/polar_block_avg_if.sv | 28 ++
 rtl/polar_block_avg.sv | 125 ++++++++++++
 tb/tb_polar_block_avg.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/polar_block_avg_pkg.sv
// Shared types, defaults and helpers for the polar block averager.
package polar_block_avg_pkg;

  localparam int unsigned POLAR_DATA_W = 32;
  localparam int unsigned POLAR_LOG2_N = 2;

  typedef logic signed [POLAR_DATA_W-1:0] phase_t;

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_FILLING = 1'b1
  } blk_state_e;

  // Wrapped signed difference a - b of two binary angles.
  function automatic phase_t phase_delta(input phase_t a, input phase_t b);
    return a - b;
  endfunction

  // Accumulator width that cannot overflow over 2^log2_n signed samples.
  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned log2_n);
    return data_w + log2_n + 1;
  endfunction

endpackage

// File: rtl/polar_block_avg_if.sv
// Sample stream in / averaged result out for polar_block_avg.
interface polar_block_avg_if
  import polar_block_avg_pkg::*;
#(
  parameter int unsigned DATA_W = POLAR_DATA_W,
  parameter int unsigned LOG2_N = POLAR_LOG2_N
);

  logic                     i_vld;
  logic signed [DATA_W-1:0] i_mag;
  logic        [DATA_W-1:0] i_phase;
  logic                     i_clr;
  logic                     o_vld;
  logic        [DATA_W-1:0] o_mag;
  logic        [DATA_W-1:0] o_phase;
  logic        [LOG2_N:0]   o_cnt;

  modport master (
    output i_vld, i_mag, i_phase, i_clr,
    input  o_vld, o_mag, o_phase, o_cnt
  );

  modport slave (
    input  i_vld, i_mag, i_phase, i_clr,
    output o_vld, o_mag, o_phase, o_cnt
  );

endinterface

// File: rtl/polar_block_avg.sv
// Averages magnitude and wrap-safe phase over blocks of 2^LOG2_N valid samples.
module polar_block_avg
  import polar_block_avg_pkg::*;
#(
  parameter int unsigned DATA_W = POLAR_DATA_W,
  parameter int unsigned LOG2_N = POLAR_LOG2_N
) (
  input  logic               clk,
  input  logic               rst,
  polar_block_avg_if.slave   io_bus
);

  localparam int unsigned ACC_W = acc_w(DATA_W, LOG2_N);
  localparam int unsigned CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] BLK_N = CNT_W'(1 << LOG2_N);

  blk_state_e               r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [ACC_W-1:0]  r_mag_acc;
  logic signed [ACC_W-1:0]  r_dph_acc;
  logic [DATA_W-1:0]        r_ref;
  logic                     r_o_vld;
  logic [DATA_W-1:0]        r_o_mag;
  logic [DATA_W-1:0]        r_o_phase;

  blk_state_e               w_state_nxt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic signed [ACC_W-1:0]  w_mag_nxt;
  logic signed [ACC_W-1:0]  w_dph_nxt;
  logic [DATA_W-1:0]        w_ref_nxt;
  logic                     w_done;
  logic                     w_first;
  logic                     w_full;
  logic [CNT_W-1:0]         w_cnt_inc;
  logic signed [DATA_W-1:0] w_delta;
  logic signed [ACC_W-1:0]  w_mag_fin;
  logic signed [ACC_W-1:0]  w_dph_fin;
  logic [DATA_W-1:0]        w_ref_fin;
  logic [DATA_W-1:0]        w_o_mag_nxt;
  logic [DATA_W-1:0]        w_o_phase_nxt;

  // Sums including the current sample; a clear makes it the first of a new block.
  always_comb begin
    w_first = (r_state == ST_EMPTY) || io_bus.i_clr;
    w_delta = io_bus.i_phase - r_ref;
    if (w_first) begin
      w_ref_fin = io_bus.i_phase;
      w_mag_fin = ACC_W'(io_bus.i_mag);
      w_dph_fin = '0;
      w_cnt_inc = CNT_W'(1);
    end else begin
      w_ref_fin = r_ref;
      w_mag_fin = r_mag_acc + ACC_W'(io_bus.i_mag);
      w_dph_fin = r_dph_acc + ACC_W'(w_delta);
      w_cnt_inc = r_cnt + CNT_W'(1);
    end
    w_full        = (w_cnt_inc == BLK_N);
    w_o_mag_nxt   = DATA_W'(w_mag_fin >>> LOG2_N);
    w_o_phase_nxt = w_ref_fin + DATA_W'(w_dph_fin >>> LOG2_N);
  end

  // Block control: EMPTY until a sample arrives, FILLING until the Nth completes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mag_nxt   = r_mag_acc;
    w_dph_nxt   = r_dph_acc;
    w_ref_nxt   = r_ref;
    w_done      = 1'b0;
    if (io_bus.i_clr) begin
      w_state_nxt = ST_EMPTY;
      w_cnt_nxt   = '0;
      // A clearing sample that would itself fill the block is dropped with it.
      if (io_bus.i_vld && !w_full) begin
        w_state_nxt = ST_FILLING;
        w_cnt_nxt   = w_cnt_inc;
        w_mag_nxt   = w_mag_fin;
        w_dph_nxt   = w_dph_fin;
        w_ref_nxt   = w_ref_fin;
      end
    end else if (io_bus.i_vld) begin
      if (w_full) begin
        w_done      = 1'b1;
        w_state_nxt = ST_EMPTY;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = ST_FILLING;
        w_cnt_nxt   = w_cnt_inc;
        w_mag_nxt   = w_mag_fin;
        w_dph_nxt   = w_dph_fin;
        w_ref_nxt   = w_ref_fin;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_EMPTY;
      r_cnt     <= '0;
      r_mag_acc <= '0;
      r_dph_acc <= '0;
      r_ref     <= '0;
      r_o_vld   <= 1'b0;
      r_o_mag   <= '0;
      r_o_phase <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mag_acc <= w_mag_nxt;
      r_dph_acc <= w_dph_nxt;
      r_ref     <= w_ref_nxt;
      r_o_vld   <= w_done;
      if (w_done) begin
        r_o_mag   <= w_o_mag_nxt;
        r_o_phase <= w_o_phase_nxt;
      end
    end
  end

  assign io_bus.o_vld   = r_o_vld;
  assign io_bus.o_mag   = r_o_mag;
  assign io_bus.o_phase = r_o_phase;
  assign io_bus.o_cnt   = r_cnt;

endmodule

// File: tb/tb_polar_block_avg.sv
// Scoreboard bench for polar_block_avg: queue-based block model vs DUT outputs.
module tb_polar_block_avg;
  import polar_block_avg_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned L2N = 2;
  localparam int          N   = 4;

  typedef struct {
    logic [31:0] mag;
    logic [31:0] phase;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_seen = 1'b0;
  int   cyc = 0;
  int   exp_cnt = 0;
  int   exp_cnt_nxt = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t        sb_q[$];
  logic [31:0] blk_mag[$];
  logic [31:0] blk_ph[$];
  logic [31:0] last_mag = '0;
  logic [31:0] last_ph  = '0;

  always #5 clk = ~clk;

  polar_block_avg_if #(.DATA_W(DW), .LOG2_N(L2N)) bus ();

  polar_block_avg #(.DATA_W(DW), .LOG2_N(L2N)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    exp_cnt  <= exp_cnt_nxt;
    rst_seen <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint floor_div(input longint s, input longint d);
    longint q;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  // Block model: average of the collected samples, phase as mean offset from the first.
  function automatic exp_t block_result(input int due);
    exp_t   e;
    longint msum = 0;
    longint dsum = 0;
    logic [31:0] d;
    for (int i = 0; i < N; i++) begin
      msum += longint'($signed(blk_mag[i]));
      d = blk_ph[i] - blk_ph[0];
      dsum += longint'($signed(d));
    end
    e.mag   = 32'(floor_div(msum, N));
    e.phase = blk_ph[0] + 32'(floor_div(dsum, N));
    e.due   = due;
    return e;
  endfunction

  task automatic send(input logic vld, input logic clr, input logic [31:0] m, input logic [31:0] p);
    @(posedge clk);
    #1;
    bus.i_vld   = vld;
    bus.i_clr   = clr;
    bus.i_mag   = m;
    bus.i_phase = p;
    if (clr) begin
      blk_mag.delete();
      blk_ph.delete();
    end
    if (vld) begin
      blk_mag.push_back(m);
      blk_ph.push_back(p);
      if (blk_mag.size() == N) begin
        if (!clr) sb_q.push_back(block_result(cyc + 1));
        blk_mag.delete();
        blk_ph.delete();
      end
    end
    exp_cnt_nxt = blk_mag.size();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0, $urandom, $urandom);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.i_vld = 1'b0;
    bus.i_clr = 1'b0;
    blk_mag.delete();
    blk_ph.delete();
    exp_cnt_nxt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compares every cycle, popping the scoreboard on each output pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        chk("reset_vld", 32'(bus.o_vld), 32'd0);
        chk("reset_mag", bus.o_mag, 32'd0);
        chk("reset_phase", bus.o_phase, 32'd0);
        last_mag = '0;
        last_ph  = '0;
      end else if (bus.o_vld) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_vld", 32'(bus.o_vld), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("latency", 32'(cyc), 32'(e.due));
          chk("avg_mag", bus.o_mag, e.mag);
          chk("avg_phase", bus.o_phase, e.phase);
          last_mag = e.mag;
          last_ph  = e.phase;
        end
      end else begin
        chk("hold_mag", bus.o_mag, last_mag);
        chk("hold_phase", bus.o_phase, last_ph);
        if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
          e = sb_q.pop_front();
          chk("missing_vld", 32'(bus.o_vld), 32'd1);
        end
      end
      chk("cnt", 32'(bus.o_cnt), 32'(exp_cnt));
    end
  end

  initial begin
    logic [31:0] gmag[8];
    logic [31:0] gph[8];
    logic [31:0] base;
    bus.i_vld   = 1'b0;
    bus.i_clr   = 1'b0;
    bus.i_mag   = '0;
    bus.i_phase = '0;
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Plain average with constant phase.
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 32'(100 * (i + 1)), 32'h1000_0000);
    idle(2);

    // Cluster straddling +/-pi.
    for (int i = 0; i < 4; i++)
      send(1'b1, 1'b0, 32'(10 * (i + 1)), (i % 2 == 0) ? 32'h7FFF_FF00 : 32'h8000_0100);
    idle(1);

    // Floor on magnitude and on a negative phase offset.
    send(1'b1, 1'b0, 32'd1, 32'h0000_0000);
    send(1'b1, 1'b0, 32'd1, 32'hFFFF_FFFF);
    send(1'b1, 1'b0, 32'd1, 32'hFFFF_FFFF);
    send(1'b1, 1'b0, 32'd2, 32'hFFFF_FFFF);
    idle(2);

    // Eight samples back-to-back, then the same eight with random gaps.
    for (int i = 0; i < 8; i++) begin
      gmag[i] = $urandom_range(0, 32'h7FFF_FFFF);
      gph[i]  = $urandom;
    end
    for (int i = 0; i < 8; i++) send(1'b1, 1'b0, gmag[i], gph[i]);
    idle(2);
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 1'b0, gmag[i], gph[i]);
      idle($urandom_range(0, 3));
    end
    idle(2);

    // Clear with a valid sample after two samples, then three more.
    send(1'b1, 1'b0, 32'd500, 32'h2000_0000);
    send(1'b1, 1'b0, 32'd600, 32'h2000_0000);
    send(1'b1, 1'b1, 32'd40, 32'h3000_0000);
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 32'(44 + i), 32'h3000_0010);
    idle(2);

    // Clear coincident with the fourth sample.
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 32'd9, 32'h0);
    send(1'b1, 1'b1, 32'd9, 32'h0);
    send(1'b0, 1'b1, 32'd0, 32'h0);
    idle(2);

    // Reset mid-block, then a clean block.
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 32'd7777, 32'h5555_0000);
    do_reset();
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 32'(8 * (i + 1)), 32'h4000_0000 + 32'(i));
    idle(2);

    // Random traffic, phases often clustered around +/-pi.
    for (int i = 0; i < 400; i++) begin
      base = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : $urandom;
      send($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0,
           $urandom_range(0, 32'h7FFF_FFFF), base + 32'($signed(10'($urandom))));
    end
    idle(4);

    chk("drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
